fir_mac_sched: RTL and testbench

- Single-clock sequencer between the async FIFO read side (`fifo_top`, read domain) and a shared single-MAC configurable FIR datapath.
- Pops one sample per output when the FIFO is non-empty and writes it into a circular sample RAM.
- Steps tap addresses over the sample and coefficient RAMs while driving the accumulator controls, then flags the result valid.
- Also gates coefficient writes, which are accepted only when the block is idle.

---
 rtl/fir_pkg.sv | 20 ++
 rtl/fir_mac_sched_if.sv | 42 ++++
 rtl/fir_tap_cnt.sv | 39 +++
 rtl/fir_mac_sched.sv | 161 ++++++++++++++++
 tb/tb_fir_mac_sched.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared types and default sizing for the single-MAC FIR scheduler.
package fir_pkg;

  localparam int unsigned DW_DEF      = 8;
  localparam int unsigned CW_DEF      = 8;
  localparam int unsigned AW_DEF      = 4;
  localparam int unsigned MAC_LAT_DEF = 2;

  // MAC_LAT is limited to 1..7, so the drain counter never needs more than 3 bits.
  localparam int unsigned DRN_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/fir_mac_sched_if.sv
// Bus bundle between the FIR scheduler, the FIFO read side and the MAC datapath.
interface fir_mac_sched_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 8,
  parameter int unsigned AW = 4
);

  logic          iEMPT;
  logic [DW-1:0] iRDAT;
  logic          oRINC;
  logic [AW-1:0] iTAPS;
  logic          iCFG_WE;
  logic [AW-1:0] iCFG_ADDR;
  logic [CW-1:0] iCFG_DAT;
  logic          oCOEF_WE;
  logic [AW-1:0] oCOEF_ADDR;
  logic [CW-1:0] oCOEF_DAT;
  logic          oSMP_WE;
  logic [AW-1:0] oSMP_ADDR;
  logic [DW-1:0] oSMP_DAT;
  logic          oACC_CLR;
  logic          oACC_EN;
  logic          oOUT_VLD;
  logic          iOUT_RDY;
  logic          oBUSY;
  logic          oCFG_ERR;

  // Scheduler side.
  modport master (
    input  iEMPT, iRDAT, iTAPS, iCFG_WE, iCFG_ADDR, iCFG_DAT, iOUT_RDY,
    output oRINC, oCOEF_WE, oCOEF_ADDR, oCOEF_DAT, oSMP_WE, oSMP_ADDR,
           oSMP_DAT, oACC_CLR, oACC_EN, oOUT_VLD, oBUSY, oCFG_ERR
  );

  // Environment side: FIFO, RAMs, accumulator and output consumer.
  modport slave (
    output iEMPT, iRDAT, iTAPS, iCFG_WE, iCFG_ADDR, iCFG_DAT, iOUT_RDY,
    input  oRINC, oCOEF_WE, oCOEF_ADDR, oCOEF_DAT, oSMP_WE, oSMP_ADDR,
           oSMP_DAT, oACC_CLR, oACC_EN, oOUT_VLD, oBUSY, oCFG_ERR
  );

endinterface

// File: rtl/fir_tap_cnt.sv
// Tap index counter for the MAC loop: clear, enable and a terminal flag at k == ntap.
module fir_tap_cnt
  import fir_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [AW-1:0] ntap_i,
  output logic [AW-1:0] k_o,
  output logic          term_o
);

  logic [AW-1:0] k_q;
  logic [AW-1:0] k_d;

  always_comb begin
    k_d = k_q;
    if (clr_i) begin
      k_d = '0;
    end else if (en_i) begin
      k_d = k_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

  assign k_o    = k_q;
  assign term_o = (k_q == ntap_i);

endmodule

// File: rtl/fir_mac_sched.sv
// Sequencer for a shared single-MAC FIR: pops one FIFO sample per output, walks the taps,
// drains the MAC pipeline and flags the result. Option: FIR_MAC_SCHED_BACKPRESSURE_EN.
module fir_mac_sched
  import fir_pkg::*;
#(
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned CW      = CW_DEF,
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned MAC_LAT = MAC_LAT_DEF
) (
  input  logic            iCLK,
  input  logic            iRSTN,
  fir_mac_sched_if.master bus
);

  localparam int unsigned DRN_LAST = MAC_LAT - 1;

  state_e           state_q;
  state_e           state_d;
  logic [AW-1:0]    hp_q;
  logic [AW-1:0]    hp_d;
  logic [AW-1:0]    ntap_q;
  logic [AW-1:0]    ntap_d;
  logic [DRN_W-1:0] drn_q;
  logic [DRN_W-1:0] drn_d;

  logic          tap_clr_c;
  logic          tap_en_c;
  logic [AW-1:0] k;
  logic          tap_term;

  logic          rinc_c;
  logic          coef_we_c;
  logic [AW-1:0] coef_addr_c;
  logic [CW-1:0] coef_dat_c;
  logic          smp_we_c;
  logic [AW-1:0] smp_addr_c;
  logic [DW-1:0] smp_dat_c;
  logic          acc_clr_c;
  logic          acc_en_c;
  logic          out_vld_c;
  logic          done_exit_c;

  fir_tap_cnt #(
    .AW (AW)
  ) u_tap_cnt (
    .clk    (iCLK),
    .rst_n  (iRSTN),
    .clr_i  (tap_clr_c),
    .en_i   (tap_en_c),
    .ntap_i (ntap_q),
    .k_o    (k),
    .term_o (tap_term)
  );

`ifdef FIR_MAC_SCHED_BACKPRESSURE_EN
  assign done_exit_c = bus.iOUT_RDY;
`else
  logic unused_out_rdy;
  assign unused_out_rdy = bus.iOUT_RDY;
  assign done_exit_c    = 1'b1;
`endif

  // Next-state and strobe decode; outputs depend only on state plus the same-cycle inputs they forward.
  always_comb begin
    state_d     = state_q;
    hp_d        = hp_q;
    ntap_d      = ntap_q;
    drn_d       = drn_q;
    tap_clr_c   = 1'b0;
    tap_en_c    = 1'b0;
    rinc_c      = 1'b0;
    coef_we_c   = 1'b0;
    coef_addr_c = '0;
    coef_dat_c  = '0;
    smp_we_c    = 1'b0;
    smp_addr_c  = '0;
    smp_dat_c   = '0;
    acc_clr_c   = 1'b0;
    acc_en_c    = 1'b0;
    out_vld_c   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A coefficient write wins over a fetch; the sample waits in the FIFO.
        if (bus.iCFG_WE) begin
          coef_we_c   = 1'b1;
          coef_addr_c = bus.iCFG_ADDR;
          coef_dat_c  = bus.iCFG_DAT;
        end else if (!bus.iEMPT) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        rinc_c     = 1'b1;
        smp_we_c   = 1'b1;
        smp_addr_c = hp_q;
        smp_dat_c  = bus.iRDAT;
        ntap_d     = bus.iTAPS;
        tap_clr_c  = 1'b1;
        state_d    = ST_MAC;
      end
      ST_MAC: begin
        acc_en_c    = 1'b1;
        acc_clr_c   = (k == '0);
        smp_addr_c  = hp_q - k;
        coef_addr_c = k;
        tap_en_c    = 1'b1;
        if (tap_term) begin
          drn_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drn_q == DRN_W'(DRN_LAST)) begin
          state_d = ST_DONE;
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      ST_DONE: begin
        out_vld_c = 1'b1;
        if (done_exit_c) begin
          hp_d    = hp_q + AW'(1);
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state_q <= ST_IDLE;
      hp_q    <= '0;
      ntap_q  <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      ntap_q  <= ntap_d;
      drn_q   <= drn_d;
    end
  end

  assign bus.oRINC      = rinc_c;
  assign bus.oCOEF_WE   = coef_we_c;
  assign bus.oCOEF_ADDR = coef_addr_c;
  assign bus.oCOEF_DAT  = coef_dat_c;
  assign bus.oSMP_WE    = smp_we_c;
  assign bus.oSMP_ADDR  = smp_addr_c;
  assign bus.oSMP_DAT   = smp_dat_c;
  assign bus.oACC_CLR   = acc_clr_c;
  assign bus.oACC_EN    = acc_en_c;
  assign bus.oOUT_VLD   = out_vld_c;
  assign bus.oBUSY      = (state_q != ST_IDLE);
  assign bus.oCFG_ERR   = bus.iCFG_WE && (state_q != ST_IDLE);

endmodule

// File: tb/tb_fir_mac_sched.sv
// Self-checking bench for fir_mac_sched: FIFO model, per-sample scoreboard and scenario tasks.
module tb_fir_mac_sched;

  localparam int MAC_LAT = 2;

  typedef struct {
    logic [7:0] d;
    logic [3:0] addr;
    int         ntap;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  fir_mac_sched_if #(.DW(8), .CW(8), .AW(4)) bus ();

  fir_mac_sched #(
    .DW      (8),
    .CW      (8),
    .AW      (4),
    .MAC_LAT (MAC_LAT)
  ) dut (
    .iCLK  (clk),
    .iRSTN (rstn),
    .bus   (bus)
  );

  exp_t       exp_q[$];
  exp_t       cur;
  logic [7:0] fifo[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_rinc = 0;
  int n_out = 0;
  int n_push = 0;
  int load_cyc = 0;
  int k_mon = 0;
  bit in_run = 1'b0;
  bit vld_prev = 1'b0;

  logic       s_cfg_we = 1'b0;
  logic [3:0] s_cfg_addr = 4'h0;
  logic [7:0] s_cfg_dat = 8'h00;
  logic [3:0] s_taps = 4'h3;
  logic       s_rdy = 1'b1;

  function automatic logic [31:0] all_outs();
    return {bus.oRINC, bus.oCOEF_WE, bus.oCOEF_ADDR, bus.oCOEF_DAT, bus.oSMP_WE,
            bus.oSMP_ADDR, bus.oSMP_DAT, bus.oACC_CLR, bus.oACC_EN, bus.oOUT_VLD,
            bus.oBUSY, bus.oCFG_ERR};
  endfunction

  task automatic push_sample(input logic [7:0] d, input int ntap);
    exp_t e;
    e.d    = d;
    e.addr = 4'(n_push);
    e.ntap = ntap;
    exp_q.push_back(e);
    fifo.push_back(d);
    n_push++;
  endtask

  // One clock: drive inputs after the falling edge, sample #1 later, scoreboard the outputs.
  task automatic cycle();
    logic [3:0] exp_sa;
    @(negedge clk);
    bus.iCFG_WE   = s_cfg_we;
    bus.iCFG_ADDR = s_cfg_addr;
    bus.iCFG_DAT  = s_cfg_dat;
    bus.iTAPS     = s_taps;
    bus.iOUT_RDY  = s_rdy;
    bus.iEMPT     = (fifo.size() == 0);
    bus.iRDAT     = (fifo.size() != 0) ? fifo[0] : 8'h00;
    #1;
    cyc++;
    if (bus.oRINC) begin
      n_rinc++;
      n_chk++;
      if (exp_q.size() == 0 || fifo.size() == 0) begin
        n_err++;
        $display("FAIL rinc: pop with empty FIFO at cycle %0d", cyc);
      end else begin
        cur = exp_q.pop_front();
        void'(fifo.pop_front());
        n_chk++;
        if ({bus.oSMP_WE, bus.oSMP_ADDR, bus.oSMP_DAT} !== {1'b1, cur.addr, cur.d}) begin
          n_err++;
          $display("FAIL load_write: got we=%0b addr=%0d dat=%02h expected we=1 addr=%0d dat=%02h",
                   bus.oSMP_WE, bus.oSMP_ADDR, bus.oSMP_DAT, cur.addr, cur.d);
        end
        in_run   = 1'b1;
        load_cyc = cyc;
        k_mon    = 0;
      end
    end
    if (bus.oACC_EN) begin
      n_chk++;
      if (!in_run) begin
        n_err++;
        $display("FAIL acc_en: strobe outside a run at cycle %0d", cyc);
      end else begin
        exp_sa = cur.addr - 4'(k_mon);
        if ({bus.oACC_CLR, bus.oSMP_ADDR, bus.oCOEF_ADDR, bus.oSMP_WE, bus.oCOEF_WE} !==
            {(k_mon == 0), exp_sa, 4'(k_mon), 1'b0, 1'b0}) begin
          n_err++;
          $display("FAIL mac_tap k=%0d: got clr=%0b smp=%0d coef=%0d expected clr=%0b smp=%0d coef=%0d",
                   k_mon, bus.oACC_CLR, bus.oSMP_ADDR, bus.oCOEF_ADDR, (k_mon == 0), exp_sa, k_mon);
        end
        k_mon++;
      end
    end
    if (bus.oOUT_VLD && !vld_prev) begin
      n_out++;
      n_chk++;
      if (!in_run) begin
        n_err++;
        $display("FAIL out_vld: result without a load at cycle %0d", cyc);
      end else if ((cyc - load_cyc) != cur.ntap + MAC_LAT + 2 || k_mon != cur.ntap + 1) begin
        n_err++;
        $display("FAIL run_len: got load_to_done=%0d mac=%0d expected %0d and %0d",
                 cyc - load_cyc, k_mon, cur.ntap + MAC_LAT + 2, cur.ntap + 1);
      end
      in_run = 1'b0;
    end
    vld_prev = bus.oOUT_VLD;
  endtask

  task automatic wait_outs(input int target, input int budget, input string tag);
    int n = 0;
    while (n_out < target && n < budget) begin
      cycle();
      n++;
    end
    n_chk++;
    if (n_out < target) begin
      n_err++;
      $display("FAIL %s timeout: outputs %0d expected %0d", tag, n_out, target);
    end
  endtask

  task automatic wait_rinc(input string tag);
    int r0 = n_rinc;
    int n = 0;
    while (n_rinc == r0 && n < 10) begin
      cycle();
      n++;
    end
    n_chk++;
    if (n_rinc == r0) begin
      n_err++;
      $display("FAIL %s: no pop within 10 cycles got %0d expected %0d", tag, n_rinc, r0 + 1);
    end
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    fifo.delete();
    exp_q.delete();
    n_push   = 0;
    in_run   = 1'b0;
    vld_prev = 1'b0;
    s_cfg_we = 1'b0;
    s_rdy    = 1'b1;
    repeat (3) cycle();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    rstn = 1'b0;
    cycle();
    n_chk++;
    if (all_outs() !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outs: got %08h expected 00000000", all_outs());
    end
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      n_chk++;
      if (all_outs() !== 32'h0) begin
        n_err++;
        $display("FAIL idle_empty cycle %0d: got %08h expected 00000000", i, all_outs());
      end
    end
  endtask

  task automatic test_single();
    int r0 = n_rinc;
    int o0 = n_out;
    s_taps = 4'd3;
    push_sample(8'h05, 3);
    wait_outs(o0 + 1, 40, "single");
    cycle();
    n_chk++;
    if ({n_rinc - r0, bus.oBUSY} !== {32'd1, 1'b0}) begin
      n_err++;
      $display("FAIL single_end: got pops=%0d busy=%0b expected pops=1 busy=0", n_rinc - r0, bus.oBUSY);
    end
  endtask

  task automatic test_back_to_back();
    int r0;
    apply_reset();
    r0 = n_rinc;
    s_taps = 4'd15;
    for (int i = 0; i < 17; i++) push_sample(8'(8'h10 + i), 15);
    wait_outs(17 + n_out, 1000, "b2b");
    repeat (5) cycle();
    n_chk++;
    if (n_rinc - r0 !== 17 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL b2b_count: got pops=%0d pending=%0d expected pops=17 pending=0", n_rinc - r0, exp_q.size());
    end
  endtask

  task automatic test_cfg();
    int o0 = n_out;
    s_taps     = 4'd3;
    s_cfg_we   = 1'b1;
    s_cfg_addr = 4'd4;
    s_cfg_dat  = 8'h7F;
    push_sample(8'hA5, 3);
    cycle();
    n_chk++;
    if ({bus.oCOEF_WE, bus.oCOEF_ADDR, bus.oCOEF_DAT, bus.oRINC, bus.oCFG_ERR} !== {1'b1, 4'd4, 8'h7F, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL cfg_idle: got we=%0b addr=%0d dat=%02h rinc=%0b err=%0b expected we=1 addr=4 dat=7f rinc=0 err=0",
               bus.oCOEF_WE, bus.oCOEF_ADDR, bus.oCOEF_DAT, bus.oRINC, bus.oCFG_ERR);
    end
    s_cfg_we = 1'b0;
    wait_rinc("cfg_then_load");
    cycle();
    s_cfg_we = 1'b1;
    cycle();
    n_chk++;
    if ({bus.oCFG_ERR, bus.oCOEF_WE, bus.oACC_EN} !== 3'b101) begin
      n_err++;
      $display("FAIL cfg_busy: got err=%0b we=%0b acc_en=%0b expected err=1 we=0 acc_en=1",
               bus.oCFG_ERR, bus.oCOEF_WE, bus.oACC_EN);
    end
    s_cfg_we = 1'b0;
    cycle();
    n_chk++;
    if (bus.oCFG_ERR !== 1'b0) begin
      n_err++;
      $display("FAIL cfg_err_pulse: got %0b expected 0", bus.oCFG_ERR);
    end
    wait_outs(o0 + 1, 40, "cfg");
  endtask

  task automatic test_taps_change();
    int o0 = n_out;
    s_taps = 4'd3;
    push_sample(8'h11, 3);
    push_sample(8'h22, 7);
    wait_rinc("taps_load");
    cycle();
    s_taps = 4'd7;
    wait_outs(o0 + 2, 100, "taps");
    n_chk++;
    if (n_out - o0 !== 2) begin
      n_err++;
      $display("FAIL taps_outs: got %0d expected 2", n_out - o0);
    end
  endtask

  task automatic test_reset_drain();
    int o0;
    s_taps = 4'd3;
    push_sample(8'h33, 3);
    wait_rinc("drain_load");
    repeat (5) cycle();
    n_chk++;
    if ({bus.oBUSY, bus.oACC_EN, bus.oOUT_VLD} !== 3'b100) begin
      n_err++;
      $display("FAIL drain_state: got busy=%0b acc_en=%0b vld=%0b expected busy=1 acc_en=0 vld=0",
               bus.oBUSY, bus.oACC_EN, bus.oOUT_VLD);
    end
    rstn = 1'b0;
    #1;
    n_chk++;
    if (all_outs() !== 32'h0) begin
      n_err++;
      $display("FAIL reset_drain_outs: got %08h expected 00000000", all_outs());
    end
    o0 = n_out;
    exp_q.delete();
    fifo.delete();
    n_push   = 0;
    in_run   = 1'b0;
    vld_prev = 1'b0;
    repeat (4) cycle();
    rstn = 1'b1;
    repeat (4) cycle();
    n_chk++;
    if (n_out !== o0) begin
      n_err++;
      $display("FAIL reset_abort: got %0d results expected %0d", n_out, o0);
    end
    push_sample(8'h44, 3);
    wait_outs(o0 + 1, 40, "after_reset");
  endtask

  task automatic test_out_hold();
    int cnt = 1;
    int n = 0;
    int o0 = n_out;
    s_taps = 4'd3;
    s_rdy  = 1'b0;
    push_sample(8'h55, 3);
    wait_outs(o0 + 1, 40, "hold_first");
`ifdef FIR_MAC_SCHED_BACKPRESSURE_EN
    while (n < 15) begin
      if (cnt >= 5) s_rdy = 1'b1;
      s_cfg_we = (cnt == 2);
      cycle();
      n++;
      if (s_cfg_we) begin
        n_chk++;
        if ({bus.oCFG_ERR, bus.oCOEF_WE, bus.oOUT_VLD} !== 3'b101) begin
          n_err++;
          $display("FAIL cfg_in_done: got err=%0b we=%0b vld=%0b expected err=1 we=0 vld=1",
                   bus.oCFG_ERR, bus.oCOEF_WE, bus.oOUT_VLD);
        end
      end
      if (!bus.oOUT_VLD) break;
      cnt++;
    end
    s_cfg_we = 1'b0;
    n_chk++;
    if (cnt !== 6) begin
      n_err++;
      $display("FAIL vld_hold: got %0d cycles expected 6", cnt);
    end
`else
    while (n < 10) begin
      cycle();
      n++;
      if (!bus.oOUT_VLD) break;
      cnt++;
    end
    n_chk++;
    if (cnt !== 1) begin
      n_err++;
      $display("FAIL vld_no_hold: got %0d cycles expected 1", cnt);
    end
`endif
    s_rdy = 1'b1;
    push_sample(8'h66, 3);
    wait_outs(o0 + 2, 40, "after_hold");
  endtask

  initial begin
    bus.iEMPT     = 1'b1;
    bus.iRDAT     = 8'h00;
    bus.iTAPS     = 4'h3;
    bus.iCFG_WE   = 1'b0;
    bus.iCFG_ADDR = 4'h0;
    bus.iCFG_DAT  = 8'h00;
    bus.iOUT_RDY  = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_cfg();
    test_taps_change();
    test_reset_drain();
    test_out_hold();
    repeat (3) cycle();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
